// File: rtl/vec_ctrl_pkg.sv
// vec_ctrl_pkg -- shared definitions for the vector ALU sequencer.
//   state_t  : sequencer FSM states
//   OP_*     : ALU opcode encodings carried on cmd_op / alu_op
package vec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [2:0] OP_PASS  = 3'b000;
  localparam logic [2:0] OP_GRAD  = 3'b001;
  localparam logic [2:0] OP_BLEND = 3'b010;

endpackage

// File: rtl/vec_addr_gen.sv
// vec_addr_gen -- element counter plus the three base+i address adders.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   clr               : zero the element counter (command acceptance)
//   inc               : advance to the next element (end of a write)
//   src_a/src_b/dst   : latched base addresses
//   len               : latched element count (nonzero whenever last is used)
//   addr_a/b/d        : base + i, wrapping modulo 2^ADDR_W
//   last              : current element is the final one
module vec_addr_gen
  import vec_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [CNT_W-1:0]  len,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_d,
  output logic              last
);

  logic [CNT_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + CNT_W'(1);
    end
  end

  // Adders are ADDR_W wide so carries out of the top bit are dropped (wrap).
  assign addr_a = src_a + ADDR_W'(idx);
  assign addr_b = src_b + ADDR_W'(idx);
  assign addr_d = dst   + ADDR_W'(idx);
  assign last   = (idx == len - CNT_W'(1));

endmodule

// File: rtl/vec_alu_seq.sv
// vec_alu_seq -- sequences an element-wise ALU operation over memory vectors.
// For each element i: read A[src_a+i], read B[src_b+i], run the external
// combinational ALU, write the result to dst+i. Four cycles per element.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake (ready only in IDLE)
//   cmd_op, cmd_vcsub           : ALU opcode and ALU bypass request
//   cmd_src_a/src_b/dst/len     : base addresses and element count
//   abort                       : cancel the running command (no done)
//   mem_rd_en/mem_we/mem_addr/mem_wdata/mem_rdata : single memory port,
//                                 read data returns one cycle after mem_rd_en
//   alu_op/alu_vcsub/alu_a/alu_b/alu_out : external combinational ALU
//   busy, done (pulse), err_div0 (sticky)
// Build option: define VEC_DIV0_GUARD_EN to store 0 and flag err_div0 when a
// gradient operation sees a zero B operand; otherwise err_div0 is tied low.
module vec_alu_seq
  import vec_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_vcsub,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        alu_op,
  output logic              alu_vcsub,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_out,
  output logic              busy,
  output logic              done,
  output logic              err_div0
);

  state_t            state, state_nxt;
  logic              accept;
  logic [2:0]        op_q;
  logic              vcsub_q;
  logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
  logic [CNT_W-1:0]  len_q;
  logic [31:0]       alu_a_q, alu_b_q, result_q;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_d;
  logic              last;
  logic              div0;

  function automatic logic [31:0] exec_result(input logic zero_div, input logic [31:0] alu_res);
    return zero_div ? 32'd0 : alu_res;
  endfunction

  assign accept = (state == ST_IDLE) && cmd_valid;

`ifdef VEC_DIV0_GUARD_EN
  assign div0 = (op_q == OP_GRAD) && !vcsub_q && (mem_rdata == 32'd0);
`else
  assign div0 = 1'b0;
`endif

  vec_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .inc    (state == ST_WR),
    .src_a  (src_a_q),
    .src_b  (src_b_q),
    .dst    (dst_q),
    .len    (len_q),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .addr_d (addr_d),
    .last   (last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every non-IDLE transition
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nxt = (cmd_len == '0) ? ST_DONE : ST_RD_A;
      ST_RD_A: state_nxt = ST_RD_B;
      ST_RD_B: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WR;
      ST_WR:   state_nxt = last ? ST_DONE : ST_RD_A;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  // Command latch and operand/result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      vcsub_q  <= 1'b0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      err_div0 <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= cmd_op;
        vcsub_q  <= cmd_vcsub;
        src_a_q  <= cmd_src_a;
        src_b_q  <= cmd_src_b;
        dst_q    <= cmd_dst;
        len_q    <= cmd_len;
        err_div0 <= 1'b0;
      end
      if (state == ST_RD_B) alu_a_q <= mem_rdata;
      if (state == ST_EXEC) begin
        alu_b_q  <= mem_rdata;
        result_q <= exec_result(div0, alu_out);
        if (div0) err_div0 <= 1'b1;
      end
    end
  end

  // B arrives during EXEC; feed it straight to the ALU so the result can be
  // registered on the same edge and written in WR.
  assign alu_b     = (state == ST_EXEC) ? mem_rdata : alu_b_q;
  assign alu_a     = alu_a_q;
  assign alu_op    = op_q;
  assign alu_vcsub = vcsub_q;
  assign mem_wdata = result_q;

  // Output decode
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    mem_rd_en = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    case (state)
      ST_RD_A: begin mem_rd_en = 1'b1; mem_addr = addr_a; end
      ST_RD_B: begin mem_rd_en = 1'b1; mem_addr = addr_b; end
      ST_WR:   begin mem_we    = 1'b1; mem_addr = addr_d; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vec_alu_seq.sv
module tb_vec_alu_seq;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic              cmd_vcsub;
  logic [ADDR_W-1:0] cmd_src_a, cmd_src_b, cmd_dst;
  logic [CNT_W-1:0]  cmd_len;
  logic              abort;
  logic              mem_rd_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [2:0]        alu_op;
  logic              alu_vcsub;
  logic [31:0]       alu_a, alu_b, alu_out;
  logic              busy, done, err_div0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  vec_alu_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_vcsub(cmd_vcsub), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_op(alu_op),
    .alu_vcsub(alu_vcsub), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .busy(busy), .done(done), .err_div0(err_div0)
  );

  // Memory contents: a zero region at 0x0800..0x080F, elsewhere {addr, ~addr}.
  function automatic logic [31:0] memval(input logic [15:0] a);
    if (a >= 16'h0800 && a <= 16'h080F) return 32'd0;
    return {a, ~a};
  endfunction

  // External ALU behaviour
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic vc,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    if (vc) return a;
    case (op)
      3'b000: return a;
      3'b001: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b010: begin s = {1'b0, a} + {1'b0, b}; return s[32:1]; end
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic vc,
                                            input logic [15:0] aa, input logic [15:0] ba);
`ifdef VEC_DIV0_GUARD_EN
    if (op == 3'b001 && !vc && memval(ba) == 32'd0) return 32'd0;
`endif
    return alu_f(op, vc, memval(aa), memval(ba));
  endfunction

  assign alu_out = alu_f(alu_op, alu_vcsub, alu_a, alu_b);

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= memval(mem_addr);
    else           mem_rdata <= 32'h0BAD_0BAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: command progress measured in cycles since acceptance.
  bit        m_act = 0;
  int        m_c = 0;
  int        m_n = 0;
  logic [2:0]  m_op;
  logic        m_vc;
  logic [15:0] m_a, m_b, m_d;
  logic        m_err = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_act = 0;
      m_err = 0;
    end else if (m_act) begin
`ifdef VEC_DIV0_GUARD_EN
      if (m_c <= 4*m_n && (m_c-1) % 4 == 2) begin
        logic [15:0] ba;
        ba = m_b + 16'((m_c-1) / 4);
        if (m_op == 3'b001 && !m_vc && memval(ba) == 32'd0) m_err = 1;
      end
`endif
      if (abort || m_c == 4*m_n + 1) m_act = 0;
      else m_c++;
    end else if (cmd_valid) begin
      m_act = 1; m_c = 1; m_err = 0;
      m_op = cmd_op; m_vc = cmd_vcsub;
      m_a = cmd_src_a; m_b = cmd_src_b; m_d = cmd_dst; m_n = int'(cmd_len);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_rd, e_we, e_done;
      logic [15:0] ea;
      int p, k;
      e_rd = 0; e_we = 0; e_done = 0; ea = '0; p = 0; k = 0;
      if (m_act) begin
        if (m_c == 4*m_n + 1) e_done = 1;
        else begin
          p = (m_c-1) % 4;
          k = (m_c-1) / 4;
          case (p)
            0: begin e_rd = 1; ea = m_a + 16'(k); end
            1: begin e_rd = 1; ea = m_b + 16'(k); end
            2: begin
              check("alu_a", alu_a, memval(m_a + 16'(k)));
              check("alu_b", alu_b, memval(m_b + 16'(k)));
            end
            default: begin e_we = 1; ea = m_d + 16'(k); end
          endcase
        end
        check("alu_op", 32'(alu_op), 32'(m_op));
        check("alu_vcsub", 32'(alu_vcsub), 32'(m_vc));
      end
      check("cmd_ready", 32'(cmd_ready), 32'(!m_act));
      check("busy", 32'(busy), 32'(m_act));
      check("done", 32'(done), 32'(e_done));
      check("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("err_div0", 32'(err_div0), 32'(m_err));
      if (e_rd || e_we) check("mem_addr", 32'(mem_addr), 32'(ea));
      if (e_we) check("mem_wdata", mem_wdata, exp_wdata(m_op, m_vc, m_a + 16'(k), m_b + 16'(k)));
    end
  end

  // Event log for the hand-computed scenarios
  logic [15:0] rdq[$];
  logic [15:0] wq[$];
  logic [31:0] wdq[$];
  int          doneq[$];

  always @(negedge clk) begin
    if (mem_rd_en) rdq.push_back(mem_addr);
    if (mem_we) begin wq.push_back(mem_addr); wdq.push_back(mem_wdata); end
    if (done) doneq.push_back(cyc);
  end

  task automatic clear_logs();
    rdq.delete(); wq.delete(); wdq.delete(); doneq.delete();
  endtask

  task automatic send(input logic [2:0] op, input logic vc, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] d, input int n,
                      output int acc);
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_vcsub = vc;
    cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_len = CNT_W'(n);
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    check("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  logic [15:0] exp_rd[6] = '{16'h10, 16'h20, 16'h11, 16'h21, 16'h12, 16'h22};

  initial begin
    int acc;
    rst_n = 0; cmd_valid = 0; cmd_op = '0; cmd_vcsub = 0; abort = 0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_err", 32'(err_div0), 32'd0);
    rst_n = 1;
    chk_en = 1;

    // Blend, N=3
    clear_logs();
    send(3'b010, 0, 16'h10, 16'h20, 16'h30, 3, acc);
    repeat (14) @(posedge clk);
    #1;
    check("blend_nrd", 32'(rdq.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("blend_rdaddr", 32'(rdq[i]), 32'(exp_rd[i]));
    check("blend_nwr", 32'(wq.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("blend_wraddr", 32'(wq[i]), 32'h30 + 32'(i));
    check("blend_wdata0", wdq[0], 32'h0018_FFE7);
    check("blend_ndone", 32'(doneq.size()), 32'd1);
    check("blend_done_cyc", 32'(doneq[0]), 32'(acc + 13));

    // N=0
    wait_idle(20);
    clear_logs();
    send(3'b000, 0, 16'h1, 16'h2, 16'h3, 0, acc);
    repeat (3) @(posedge clk);
    #1;
    check("n0_nrd", 32'(rdq.size()), 32'd0);
    check("n0_nwr", 32'(wq.size()), 32'd0);
    check("n0_ndone", 32'(doneq.size()), 32'd1);
    check("n0_done_cyc", 32'(doneq[0]), 32'(acc + 1));

    // Address wrap
    wait_idle(20);
    clear_logs();
    send(3'b000, 0, 16'hFFFF, 16'h0100, 16'h0200, 2, acc);
    repeat (10) @(posedge clk);
    #1;
    check("wrap_rd0", 32'(rdq[0]), 32'h0000_FFFF);
    check("wrap_rd2", 32'(rdq[2]), 32'h0000_0000);

    // Abort in EXEC of the second element
    wait_idle(20);
    clear_logs();
    send(3'b000, 0, 16'h40, 16'h50, 16'h60, 4, acc);
    repeat (6) @(posedge clk);
    #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("abort_nwr", 32'(wq.size()), 32'd1);
    check("abort_ndone", 32'(doneq.size()), 32'd0);

    // Gradient with zero B
    wait_idle(20);
    clear_logs();
    send(3'b001, 0, 16'h40, 16'h0800, 16'h70, 1, acc);
    repeat (6) @(posedge clk);
    #1;
`ifdef VEC_DIV0_GUARD_EN
    check("div0_wdata", wdq[0], 32'd0);
    check("div0_err", 32'(err_div0), 32'd1);
`else
    check("div0_wdata", wdq[0], 32'hFFFF_FFFF);
    check("div0_err", 32'(err_div0), 32'd0);
`endif

    // Reset during WR, then a fresh command
    wait_idle(20);
    send(3'b010, 1, 16'h90, 16'hA0, 16'hB0, 2, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("rstwr_busy", 32'(busy), 32'd0);
    check("rstwr_ready", 32'(cmd_ready), 32'd1);
    check("rstwr_we", 32'(mem_we), 32'd0);
    check("rstwr_rd_en", 32'(mem_rd_en), 32'd0);
    check("rstwr_alu_op", 32'(alu_op), 32'd0);
    check("rstwr_vcsub", 32'(alu_vcsub), 32'd0);
    check("rstwr_alu_a", alu_a, 32'd0);
    check("rstwr_wdata", mem_wdata, 32'd0);
    clear_logs();
    send(3'b010, 0, 16'h10, 16'h20, 16'h30, 1, acc);
    repeat (6) @(posedge clk);
    #1;
    check("rstwr_ndone", 32'(doneq.size()), 32'd1);
    check("rstwr_done_cyc", 32'(doneq[0]), 32'(acc + 5));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 299) != 0);
      abort     = ($urandom_range(0, 39) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 3'($urandom_range(0, 3));
      cmd_vcsub = ($urandom_range(0, 3) == 0);
      cmd_src_a = 16'($urandom);
      cmd_src_b = ($urandom_range(0, 4) == 0) ? 16'(16'h07FE + 16'($urandom_range(0, 3)))
                                              : 16'($urandom);
      cmd_dst   = 16'($urandom);
      cmd_len   = 8'($urandom_range(0, 5));
    end
    @(posedge clk); #1;
    rst_n = 1; abort = 0; cmd_valid = 0;
    repeat (30) @(posedge clk);
    #1;
    check("final_idle", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vec_alu_seq.md
VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-002 SHALL have parameter CNT_W, default 8, element-count width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-007 SHALL have port cmd_op  input  3  ALU opcode: 000 pass, 001 gradient, 010 blend.
REQ-008 SHALL have port cmd_vcsub  input  1  ALU bypass request.
REQ-009 SHALL have ports cmd_src_a, cmd_src_b, cmd_dst  input  ADDR_W each  base addresses.
REQ-010 SHALL have port cmd_len  input  CNT_W  element count N.
REQ-011 SHALL have port abort  input  1  cancel the running command.
REQ-012 SHALL have ports mem_rd_en, mem_we  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  32; mem_rdata  input  32, valid exactly one cycle after mem_rd_en.
REQ-013 SHALL have ports alu_op  output  3; alu_vcsub  output  1; alu_a, alu_b  output  32; alu_out  input  32 (combinational ALU).
REQ-014 SHALL have ports busy  output  1; done  output  1 (one-cycle pulse); err_div0  output  1 (sticky).

Function
REQ-015 SHALL accept a command on the cycle where cmd_valid and cmd_ready are both high, latching op, vcsub, bases and N.
REQ-016 SHALL run FSM IDLE -> RD_A -> RD_B -> EXEC -> WR, then RD_A if more elements remain, else DONE -> IDLE.
REQ-017 RD_A: mem_rd_en=1, mem_addr=src_a+i; RD_B: capture mem_rdata into alu_a, mem_rd_en=1, mem_addr=src_b+i.
REQ-018 EXEC: capture mem_rdata into alu_b; on the next edge register alu_out into the result register.
REQ-019 WR: mem_we=1, mem_addr=dst+i, mem_wdata=result register; increment i.
REQ-020 SHALL take exactly 4 cycles per element, so done asserts 4N+1 cycles after acceptance.
REQ-021 Address sums SHALL wrap modulo 2^ADDR_W.
REQ-022 N=0 SHALL go IDLE -> DONE with no memory access.
REQ-023 alu_op and alu_vcsub SHALL be held constant from acceptance until return to IDLE.
REQ-024 mem_rd_en and mem_we SHALL never both be high; both SHALL be low in IDLE and DONE.
REQ-025 abort in any state other than IDLE SHALL force IDLE on the next edge, with no done pulse; a WR-state write in the abort cycle still completes.
REQ-026 abort in IDLE SHALL be ignored; cmd_valid in any non-IDLE state SHALL be ignored.
REQ-027 busy SHALL be high in every state except IDLE.

Reset
REQ-028 When rst_n is low at a clk edge: state=IDLE, i=0; busy, done, mem_rd_en, mem_we, err_div0 = 0; alu_a, alu_b, result register, alu_op = 0; alu_vcsub = 0. Reset mid-command discards the command.

Configuration
REQ-029 Macro VEC_DIV0_GUARD_EN defined: in EXEC with op=001, vcsub=0 and captured B=0, the result register SHALL load 0 instead of alu_out and err_div0 SHALL set until reset or the next acceptance.
REQ-030 VEC_DIV0_GUARD_EN undefined: alu_out SHALL always be stored; err_div0 SHALL be tied 0.

Structure
REQ-031 Package vec_ctrl_pkg SHALL hold the FSM state enum and the opcode constants OP_PASS, OP_GRAD, OP_BLEND.
REQ-032 Sub-module vec_addr_gen SHALL contain the element counter and the three base+i adders.

Verification
REQ-033 Command op=010, N=3, src_a=0x10, src_b=0x20, dst=0x30 -> reads 0x10, 0x20, 0x11, 0x21, 0x12, 0x22; writes 0x30..0x32; done at cycle 13 after acceptance.
REQ-034 N=0 -> done one cycle after acceptance; no mem_rd_en and no mem_we.
REQ-035 src_a=0xFFFF, N=2 -> second A read at 0x0000.
REQ-036 abort asserted in the EXEC state of element 1 of N=4 -> only one write occurs; no done pulse; cmd_ready high on the next cycle.
REQ-037 op=001 with B word 0 -> VEC_DIV0_GUARD_EN defined: writes 0 and err_div0=1; undefined: writes alu_out and err_div0=0.
REQ-038 rst_n low during WR -> next cycle IDLE with all outputs at reset values; a new command is then accepted normally.
